// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi stimulus/encoder path.
// The PISO shifts one WORD_W word out SYM_W bits per cycle.
package viterbi_pkg;

  localparam int WORD_W       = 16;
  localparam int SYM_W        = 2;
  localparam int SYM_PER_WORD = WORD_W / SYM_W;

  localparam logic [WORD_W-1:0] TAIL_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TAIL  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/fifo2_sync.sv
// Two-entry synchronous FIFO with an occupancy count and a synchronous flush.
// A pushed word becomes poppable in the following cycle; flush takes priority over push/pop.
module fifo2_sync
  import viterbi_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign w_push  = i_push && (r_count != 2'd2);
  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/piso_frame_ctrl.sv
// Frame sequencer in front of the 2-bit-per-cycle PISO: feeds buffered words one load at a
// time, appends all-zero tail words for trellis termination, then signals frame completion.
//
//   state | meaning
//   IDLE  | waiting for start_i; upstream words may still be prefetched
//   DATA  | loading FRAME_WORDS words popped from the FIFO
//   TAIL  | loading TAIL_WORDS zero words, FIFO untouched
//   DRAIN | waiting for the PISO to finish the last word, then frame_done_o
module piso_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_WORDS = 4,
  parameter int TAIL_WORDS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              s_valid_i,
  input  logic [WORD_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              piso_load_o,
  output logic [WORD_W-1:0] piso_data_o,
  input  logic              piso_busy_i,
  output logic              frame_active_o,
  output logic              frame_done_o,
  output logic [7:0]        word_cnt_o
);

  localparam logic [7:0] LAST_DATA = 8'(FRAME_WORDS - 1);
  localparam logic [1:0] TAIL_INIT = 2'(TAIL_WORDS);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_piso_load;
  logic [WORD_W-1:0] r_piso_data;
  logic              r_done;
  logic [7:0]        r_word_cnt;
  logic [1:0]        r_tail_left;

  logic [1:0]        w_fifo_count;
  logic [WORD_W-1:0] w_fifo_data;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_piso_free;
  logic              w_load_nxt;
  logic [WORD_W-1:0] w_data_nxt;
  logic              w_done_nxt;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_tail_ld;
  logic              w_tail_dec;

  assign s_ready_o      = (w_fifo_count != 2'd2);
  assign w_push         = s_valid_i && s_ready_o;
  // r_piso_load covers the cycle in which the PISO latches the word but busy has not risen yet
  assign w_piso_free    = !piso_busy_i && !r_piso_load;
  assign piso_load_o    = r_piso_load;
  assign piso_data_o    = r_piso_data;
  assign frame_done_o   = r_done;
  assign word_cnt_o     = r_word_cnt;
  assign frame_active_o = (r_state != IDLE);

  fifo2_sync #(.W(WORD_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (s_data_i),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_load_nxt  = 1'b0;
    w_data_nxt  = r_piso_data;
    w_done_nxt  = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_tail_ld   = 1'b0;
    w_tail_dec  = 1'b0;
    if (abort_i && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_flush     = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i && !abort_i) begin
            w_state_nxt = DATA;
            w_cnt_clr   = 1'b1;
          end
        end
        DATA: begin
          if (w_piso_free && (w_fifo_count != 2'd0)) begin
            w_pop      = 1'b1;
            w_load_nxt = 1'b1;
            w_data_nxt = w_fifo_data;
            w_cnt_inc  = 1'b1;
            if (r_word_cnt == LAST_DATA) begin
              if (TAIL_WORDS == 0) begin
                w_state_nxt = DRAIN;
              end else begin
                w_state_nxt = TAIL;
                w_tail_ld   = 1'b1;
              end
            end
          end
        end
        TAIL: begin
          if (w_piso_free) begin
            w_load_nxt = 1'b1;
            w_data_nxt = TAIL_WORD;
            w_tail_dec = 1'b1;
            if (r_tail_left == 2'd1) w_state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (w_piso_free) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_piso_load <= 1'b0;
      r_piso_data <= '0;
      r_done      <= 1'b0;
      r_word_cnt  <= 8'd0;
      r_tail_left <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_piso_load <= w_load_nxt;
      r_done      <= w_done_nxt;
      if (w_load_nxt) r_piso_data <= w_data_nxt;
      if (w_cnt_clr) begin
        r_word_cnt <= 8'd0;
      end else if (w_cnt_inc) begin
        r_word_cnt <= r_word_cnt + 8'd1;
      end
      if (w_tail_ld) begin
        r_tail_left <= TAIL_INIT;
      end else if (w_tail_dec) begin
        r_tail_left <= r_tail_left - 2'd1;
      end
    end
  end

endmodule
